// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM state enum, opcodes, ALUOp codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and status in, selects and strobes out.
interface multicycle_control_unit_if;
  import mc_ctrl_pkg::*;

  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [2:0] alu_control;
  logic       illegal_instr;
  logic       instr_retired;

  modport master (
    input  op, funct3, funct7, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, illegal_instr,
           instr_retired
  );

  modport slave (
    output op, funct3, funct7, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, illegal_instr,
           instr_retired
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder_ext.sv
// Combinational ALU decoder: ALUOp plus instruction fields to alu_control.
// EXT_ALU adds xor/sll/srl; otherwise those funct3 codes fall back to add.
module alu_decoder_ext
  import mc_ctrl_pkg::*;
#(
  parameter bit EXT_ALU = 1'b0
) (
  input  aluop_t     aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          3'b100:  alu_control = EXT_ALU ? ALU_XOR : ALU_ADD;
          3'b001:  alu_control = EXT_ALU ? ALU_SLL : ALU_ADD;
          3'b101:  alu_control = EXT_ALU ? ALU_SRL : ALU_ADD;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions over a shared memory in 3-5 cycles.
// Outputs are decoded from state (and status inputs); strobes are masked during reset.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_ALU  = 1'b0
) (
  input logic                         clk,
  input logic                         rst,
  multicycle_control_unit_if.master   bus
);

  state_t     state, next_state;
  aluop_t     aluop;
  logic       ready;
  logic       pcw, irw, mw, rw, ill, ret;
  logic       adr;
  logic [1:0] res, srca, srcb;
  logic [2:0] alu_ctl;

  assign ready = MEM_WAIT ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    aluop      = ALUOP_ADD;
    pcw        = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    ill        = 1'b0;
    ret        = 1'b0;
    adr        = 1'b0;
    res        = RES_ALUOUT;
    srca       = SRCA_PC;
    srcb       = SRCB_WDATA;
    case (state)
      FETCH: begin
        srcb       = SRCB_FOUR;
        res        = RES_ALURESULT;
        irw        = ready;
        pcw        = ready;
        next_state = ready ? DECODE : FETCH;
      end
      DECODE: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default: begin
            next_state = FETCH;
            ill        = 1'b1;
            ret        = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        srca       = SRCA_RD1;
        srcb       = SRCB_IMM;
        next_state = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr        = 1'b1;
        next_state = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        res = RES_DATA;
        rw  = 1'b1;
        ret = 1'b1;
      end
      MEMWRITE: begin
        // write strobe stays up across the stall; retire only on completion
        adr        = 1'b1;
        mw         = 1'b1;
        ret        = ready;
        next_state = ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        srca       = SRCA_RD1;
        aluop      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        srca       = SRCA_RD1;
        srcb       = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        rw  = 1'b1;
        ret = 1'b1;
      end
      BEQ: begin
        srca  = SRCA_RD1;
        aluop = ALUOP_SUB;
        pcw   = bus.zero;
        ret   = 1'b1;
      end
      JAL: begin
        srca       = SRCA_OLDPC;
        srcb       = SRCB_FOUR;
        pcw        = 1'b1;
        next_state = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  alu_decoder_ext #(.EXT_ALU(EXT_ALU)) u_alu_dec (
    .aluop       (aluop),
    .op5         (bus.op[5]),
    .funct3      (bus.funct3),
    .funct7_5    (bus.funct7[5]),
    .alu_control (alu_ctl)
  );

  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  assign bus.pc_write      = pcw & ~rst;
  assign bus.ir_write      = irw & ~rst;
  assign bus.mem_write     = mw  & ~rst;
  assign bus.reg_write     = rw  & ~rst;
  assign bus.illegal_instr = ill & ~rst;
  assign bus.instr_retired = ret & ~rst;
  assign bus.adr_src       = adr;
  assign bus.result_src    = res;
  assign bus.alu_src_a     = srca;
  assign bus.alu_src_b     = srcb;
  assign bus.imm_src       = imm_src_of(bus.op);
  assign bus.alu_control   = alu_ctl;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle control path: a Moore FSM sequences each RV32I instruction over 3-5 cycles on a shared instruction/data memory.
- Drives datapath mux selects, write enables and ALU control.
- Adds a memory-ready stall handshake and an optional extended ALU-op set.
- Sits between the instruction register (opcode, funct fields) and the multi-cycle datapath.

Parameters:
- MEM_WAIT, 1: 1 means memory states hold until mem_ready; 0 means mem_ready is ignored (treated as 1).
- EXT_ALU, 0: 1 enables xor/sll/srl decode; 0 maps those funct3 values to add.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  instruction opcode, from the IR.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  IR/OldPC load enable.
- result_src  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU B select: 00 = WriteData, 01 = Imm, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register file write enable.
- alu_control  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt, 100 xor, 110 sll, 111 srl.
- illegal_instr  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Clock, reset and state register
  - Single clk domain; rst is asynchronous and active-high.
  - Reset forces state to FETCH.
  - While rst=1, pc_write, ir_write, mem_write, reg_write, illegal_instr and instr_retired are forced to 0. All other outputs follow the FETCH decode.
  - Deasserting rst mid-instruction restarts from FETCH; partial instructions are discarded.
- Outputs
  - All outputs are combinational from state, plus op/funct/zero/mem_ready. No registered outputs.
  - imm_src is decoded from op in every state: lw/I-ALU = 00, sw = 01, beq = 10, jal = 11, other = 00.
- ALUOp to alu_control
  - ALUOp 00 gives add; 01 gives sub.
  - ALUOp 10 decodes funct3: 000 gives sub if op[5]&funct7[5], else add; 010 gives slt; 110 gives or; 111 gives and.
  - With EXT_ALU=1: 100 gives xor, 001 gives sll, 101 gives srl. With EXT_ALU=0 these give add.
  - Any other funct3 gives add.
- States (outputs not listed default to 0 / 00 selects; ALUOp 00)
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
    - ir_write = pc_write = mem_ready (when MEM_WAIT=0, both are 1).
    - When mem_ready, go to DECODE; otherwise stay.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch target precompute). Next state by opcode:
    - lw 0000011 or sw 0100011: MEMADR.
    - R-type 0110011: EXECUTER.
    - I-ALU 0010011: EXECUTEI.
    - jal 1101111: JAL.
    - beq 1100011: BEQ.
    - Other: FETCH, with illegal_instr=1 and instr_retired=1.
  - MEMADR: alu_src_a=10, alu_src_b=01. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_retired=1. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 held for the whole stall.
    - On mem_ready: instr_retired=1, next FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, ALUOp 10. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, ALUOp 10. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_retired=1. Next: FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, ALUOp 01, result_src=00.
    - pc_write = zero; instr_retired=1; next FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1. Next: ALUWB.
- Cycle counts with no stalls: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
- Each stall cycle adds 1 and asserts no additional strobes.
- instr_retired is never asserted in the same cycle as ir_write.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL;
  - opcode constants;
  - ALUOp codes;
  - alu_control codes;
  - result/srcA/srcB/imm mux encodings.
- Sub-module alu_decoder_ext (combinational, EXT_ALU parameter) maps ALUOp/op/funct3/funct7 to alu_control. The FSM stays in the top module.

Test Plan:
- rst=1 asynchronously mid-EXECUTER with mem_ready=1 -> state FETCH immediately and all write enables 0; after release, ir_write=1 on the first cycle.
- MEM_WAIT=1: fetch add (op=0110011, funct3=000, funct7=0) with mem_ready low for 2 cycles -> FETCH held 3 cycles; then DECODE, EXECUTER (alu_control=000), ALUWB (reg_write=1, instr_retired=1).
- sw with mem_ready low 1 cycle in MEMWRITE -> mem_write=1 for 2 consecutive cycles and adr_src=1; instr_retired only on the second.
- beq with zero=1 -> pc_write=1 in BEQ, alu_control=001. Repeat with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- sub (funct7=0100000) -> alu_control=001. funct3=100 with EXT_ALU=0 -> 000; with EXT_ALU=1 -> 100.
- op=1111111 -> illegal_instr pulse in DECODE, back to FETCH next cycle; jal -> JAL with pc_write=1, then ALUWB with reg_write=1.
